// File: rtl/interconnect_message_channel.sv
// interconnect_message_channel
//
// Point-to-point, credit-flow-controlled message link between two stage
// controllers. A message accepted on the sender side travels through
// LINK_LATENCY forward register stages and lands in a receive FIFO. A
// credit travels back through a LINK_LATENCY-stage delay line each time
// the receiver consumes a message. The sender holds one credit per free
// FIFO slot, so the FIFO can never overflow.
//
// Handshakes (both sides): a transfer happens on the rising clk edge that
// ends any cycle in which valid and ready are both high. Ready never
// depends on valid. Valid and data hold until the transfer completes.
//
// Ports
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-high, clears all state
//   in_data/in_valid    message offered by the sender
//   in_ready            high while at least one credit is held
//   out_data/out_valid  head of the receive FIFO
//   out_ready           receiver consumes the head this cycle
//   has_message_flying  a message is in a forward stage or in the FIFO
//   credits             sender-side credit count
//   occupancy           receive FIFO entry count
//   message_count       messages delivered so far, wraps modulo 2^32
module interconnect_message_channel #(
  parameter int CODE_DISTANCE = 5,
  parameter int DATA_WIDTH    = 2 * 3 * $clog2(CODE_DISTANCE) + 2,
  parameter int LINK_LATENCY  = 2,
  parameter int FIFO_DEPTH    = 8,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = $clog2(FIFO_DEPTH) + 1,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  has_message_flying,
  output logic [CW-1:0]         credits,
  output logic [CW-1:0]         occupancy,
  output logic [31:0]           message_count
);

  logic [LINK_LATENCY-1:0] fwd_valid_q, fwd_valid_d;
  logic [DATA_WIDTH-1:0]   fwd_data_q [LINK_LATENCY];
  logic [DATA_WIDTH-1:0]   fwd_data_d [LINK_LATENCY];
  logic [LINK_LATENCY-1:0] ret_q, ret_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           credits_q, credits_d;
  logic [31:0]             count_q, count_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];

  logic accept;
  logic deliver;
  logic fifo_write;
  logic fifo_empty;
  logic fifo_full;
  logic [31:0] inv_sum;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign in_ready   = (credits_q != '0);
  assign out_valid  = !fifo_empty;
  assign out_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign accept     = in_valid && in_ready;
  assign deliver    = out_valid && out_ready;
  // The last forward stage always has a slot waiting: its credit was
  // taken when the message was accepted.
  assign fifo_write = fwd_valid_q[LINK_LATENCY-1];

  assign credits            = credits_q;
  assign occupancy          = CW'(wr_ptr_q - rd_ptr_q);
  assign message_count      = count_q;
  assign has_message_flying = (|fwd_valid_q) || !fifo_empty;

  always_comb begin
    fwd_valid_d    = '0;
    ret_d          = '0;
    fwd_valid_d[0] = accept;
    fwd_data_d[0]  = in_data;
    ret_d[0]       = deliver;
    for (int k = 1; k < LINK_LATENCY; k++) begin
      fwd_valid_d[k] = fwd_valid_q[k-1];
      fwd_data_d[k]  = fwd_data_q[k-1];
      ret_d[k]       = ret_q[k-1];
    end

    mem_d = mem_q;
    if (fifo_write) begin
      mem_d[wr_ptr_q[AW-1:0]] = fwd_data_q[LINK_LATENCY-1];
    end
    wr_ptr_d = wr_ptr_q + PW'(fifo_write);
    rd_ptr_d = rd_ptr_q + PW'(deliver);

    // A returning credit and a new accept in the same edge cancel out.
    credits_d = credits_q + CW'(ret_q[LINK_LATENCY-1]) - CW'(accept);
    count_d   = count_q + 32'(deliver);
  end

  // Every FIFO slot is accounted for exactly once: as a credit, a message
  // in flight, a buffered message, or a credit on its way back.
  always_comb begin
    inv_sum = 32'(credits_q) + 32'(occupancy);
    for (int k = 0; k < LINK_LATENCY; k++) begin
      inv_sum = inv_sum + 32'(fwd_valid_q[k]) + 32'(ret_q[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_valid_q <= '0;
      ret_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      credits_q   <= CW'(FIFO_DEPTH);
      count_q     <= '0;
      for (int k = 0; k < LINK_LATENCY; k++) begin
        fwd_data_q[k] <= '0;
      end
    end else begin
      fwd_valid_q <= fwd_valid_d;
      ret_q       <= ret_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      credits_q   <= credits_d;
      count_q     <= count_d;
      for (int k = 0; k < LINK_LATENCY; k++) begin
        fwd_data_q[k] <= fwd_data_d[k];
      end
    end
  end

  // Storage needs no reset: entries are only read while out_valid is high.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  credit_invariant_a: assert property (@(posedge clk) disable iff (reset)
    inv_sum == 32'(FIFO_DEPTH));

  no_overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(fifo_write && fifo_full));

endmodule

// File: tb/tb_interconnect_message_channel.sv
module tb_interconnect_message_channel;
  localparam int DW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default build: LINK_LATENCY=2, FIFO_DEPTH=8
  logic [DW-1:0] in_data, out_data;
  logic          in_valid, in_ready, out_valid, out_ready, hmf;
  logic [3:0]    credits, occupancy;
  logic [31:0]   message_count;

  // Short build: LINK_LATENCY=1, FIFO_DEPTH=4
  logic [DW-1:0] in_data_b, out_data_b;
  logic          in_valid_b, in_ready_b, out_valid_b, out_ready_b, hmf_b;
  logic [2:0]    credits_b, occupancy_b;
  logic [31:0]   message_count_b;

  interconnect_message_channel dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .has_message_flying(hmf), .credits(credits), .occupancy(occupancy),
    .message_count(message_count)
  );

  interconnect_message_channel #(
    .CODE_DISTANCE(5), .LINK_LATENCY(1), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset(reset),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .has_message_flying(hmf_b), .credits(credits_b), .occupancy(occupancy_b),
    .message_count(message_count_b)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_b_q[$];
  int delivered = 0;
  int delivered_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted messages are queued, deliveries pop and compare.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        check("a_scoreboard_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("a_scoreboard_data", 32'(out_data), 32'(exp_q.pop_front()));
        delivered++;
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (out_valid_b && out_ready_b) begin
        check("b_scoreboard_nonempty", 32'(exp_b_q.size() != 0), 1);
        if (exp_b_q.size() != 0) check("b_scoreboard_data", 32'(out_data_b), 32'(exp_b_q.pop_front()));
        delivered_b++;
      end
      if (in_valid_b && in_ready_b) exp_b_q.push_back(in_data_b);
    end
  end

  initial begin
    int accepts, drops, sent, bad;
    logic acc_now;

    reset = 1'b1;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_data_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    repeat (3) tick();

    // ---- reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_flying", hmf, 0);
    check("rst_credits", credits, 8);
    check("rst_occupancy", occupancy, 0);
    check("rst_count", message_count, 0);
    check("rst_b_credits", credits_b, 4);
    check("rst_b_out_valid", out_valid_b, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // ---- single message: accept in cycle c
    in_valid = 1'b1;
    in_data = 20'h0A5A5;
    @(negedge clk);
    check("single_in_ready_c", in_ready, 1);
    check("single_credits_c", credits, 8);
    tick();
    in_valid = 1'b0;
    in_data = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("single_out_valid_c+%0d", k), out_valid, 32'(k == 3));
      check($sformatf("single_flying_c+%0d", k), hmf, 32'(k >= 1 && k <= 3));
      check($sformatf("single_credits_c+%0d", k), credits, (k <= 5) ? 7 : 8);
      if (k == 3) check("single_out_data", out_data, 20'h0A5A5);
      tick();
    end
    check("single_count", message_count, 1);

    // ---- backpressure fill
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = '0;
    accepts = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (acc_now) accepts++;
      tick();
      if (acc_now) in_data = DW'(accepts);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("fill_accepts", accepts, 8);
    check("fill_in_ready", in_ready, 0);
    check("fill_occupancy", occupancy, 8);
    check("fill_credits", credits, 0);
    check("fill_out_valid", out_valid, 1);
    check("fill_head", out_data, 0);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("fill_in_ready_p+%0d", k), in_ready, 32'(k >= 3));
      tick();
    end
    repeat (10) tick();
    check("fill_drained", exp_q.size(), 0);
    check("fill_occ_empty", occupancy, 0);
    check("fill_credits_back", credits, 8);
    check("fill_count", message_count, 9);

    // ---- streaming 100 back-to-back
    out_ready = 1'b1;
    in_valid = 1'b1;
    sent = 0;
    drops = 0;
    in_data = DW'(1000);
    for (int k = 0; k < 200 && sent < 100; k++) begin
      @(negedge clk);
      if (!in_ready) drops++;
      acc_now = in_ready;
      tick();
      if (acc_now) begin
        sent++;
        in_data = DW'(1000 + sent);
      end
    end
    in_valid = 1'b0;
    repeat (10) tick();
    check("stream_sent", sent, 100);
    check("stream_drops", drops, 0);
    check("stream_drained", exp_q.size(), 0);
    check("stream_count", message_count, 109);

    // ---- random valid/ready
    bad = 0;
    for (int k = 0; k < 10000; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data = DW'($urandom);
      @(negedge clk);
      if (credits > 8 || occupancy > 8) bad++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    check("rand_bounds", bad, 0);
    check("rand_drained", exp_q.size(), 0);
    check("rand_credits", credits, 8);
    check("rand_count", message_count, 32'(delivered));

    // ---- reset mid-stream: 2 in flight, 4 buffered
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = DW'(2000 + k);
      @(negedge clk);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("pre_rst_occupancy", occupancy, 4);
    check("pre_rst_credits", credits, 2);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_flying", hmf, 0);
    check("midrst_credits", credits, 8);
    check("midrst_occupancy", occupancy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_count", message_count, 0);
    exp_q.delete();
    exp_b_q.delete();
    delivered = 0;
    delivered_b = 0;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 20'h3C3C3;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("postrst_count", message_count, 1);
    check("postrst_drained", exp_q.size(), 0);

    // ---- short build: single-message latency 2
    out_ready_b = 1'b1;
    in_valid_b = 1'b1;
    in_data_b = 20'h12345;
    @(negedge clk);
    check("b_single_in_ready", in_ready_b, 1);
    tick();
    in_valid_b = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("b_out_valid_c+%0d", k), out_valid_b, 32'(k == 2));
      check($sformatf("b_credits_c+%0d", k), credits_b, (k <= 3) ? 3 : 4);
      if (k == 2) check("b_out_data", out_data_b, 20'h12345);
      tick();
    end

    // ---- short build: streaming 30
    in_valid_b = 1'b1;
    sent = 0;
    drops = 0;
    in_data_b = DW'(500);
    for (int k = 0; k < 60 && sent < 30; k++) begin
      @(negedge clk);
      if (!in_ready_b) drops++;
      acc_now = in_ready_b;
      tick();
      if (acc_now) begin
        sent++;
        in_data_b = DW'(500 + sent);
      end
    end
    in_valid_b = 1'b0;
    repeat (8) tick();
    check("b_stream_sent", sent, 30);
    check("b_stream_drops", drops, 0);
    check("b_stream_drained", exp_b_q.size(), 0);
    check("b_count", message_count_b, 31);
    check("b_credits_end", credits_b, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
